// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the one-hot pulse decoder.
// Holds default widths, the FSM state type and the binary-to-one-hot helper.
package onehot_decoder_pkg;

  localparam int unsigned DefaultInW  = 3;
  localparam int unsigned DefaultOutW = 1 << DefaultInW;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StGap
  } state_t;

  function automatic logic [DefaultOutW-1:0] bin_to_onehot(input logic [DefaultInW-1:0] code);
    logic [DefaultOutW-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder.sv
// Decodes an accepted line index into a one-hot pulse of programmable length, followed by a
// one-cycle all-zero gap. Optional DECODE_MASK_EN adds a per-line mask that drops masked codes.
module onehot_pulse_decoder
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned IN_W   = DefaultInW,
  parameter int unsigned HOLD_W = 4,
  localparam int unsigned OUT_W = 1 << IN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_code,
  input  logic [HOLD_W-1:0] hold_cycles,
`ifdef DECODE_MASK_EN
  input  logic [OUT_W-1:0]  mask,
  output logic              dropped,
`endif
  output logic [OUT_W-1:0]  y,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]  y_q, y_d;
  logic              dropped_q, dropped_d;
  logic [HOLD_W-1:0] hold_eff;
  logic              code_masked;

  // A zero hold request still produces a single-cycle pulse.
  assign hold_eff = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;

`ifdef DECODE_MASK_EN
  assign code_masked = mask[in_code];
  assign dropped     = dropped_q;
`else
  assign code_masked = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    dropped_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (code_masked) begin
            state_d   = StGap;
            cnt_d     = '0;
            y_d       = '0;
            dropped_d = 1'b1;
          end else begin
            state_d = StDrive;
            cnt_d   = hold_eff - HOLD_W'(1);
            y_d     = bin_to_onehot(in_code);
          end
        end
      end
      StDrive: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else begin
          state_d = StGap;
          y_d     = '0;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        y_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      y_q       <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      dropped_q <= dropped_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StGap);
  assign y        = y_q;

endmodule
